// File: rtl/kwan_cpu_pkg.sv
// Shared definitions for the kwan CPU control path: opcodes, control-word
// bit indices and masks, and the microstep depth.
package kwan_cpu_pkg;

   localparam int STEPS = 5;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam int B_HLT = 15;
   localparam int B_MI  = 14;
   localparam int B_RI  = 13;
   localparam int B_RO  = 12;
   localparam int B_IO  = 11;
   localparam int B_II  = 10;
   localparam int B_AI  = 9;
   localparam int B_AO  = 8;
   localparam int B_EO  = 7;
   localparam int B_SU  = 6;
   localparam int B_BI  = 5;
   localparam int B_OI  = 4;
   localparam int B_CE  = 3;
   localparam int B_CO  = 2;
   localparam int B_J   = 1;
   localparam int B_FI  = 0;

   localparam logic [15:0] C_HLT = 16'h1 << B_HLT;
   localparam logic [15:0] C_MI  = 16'h1 << B_MI;
   localparam logic [15:0] C_RI  = 16'h1 << B_RI;
   localparam logic [15:0] C_RO  = 16'h1 << B_RO;
   localparam logic [15:0] C_IO  = 16'h1 << B_IO;
   localparam logic [15:0] C_II  = 16'h1 << B_II;
   localparam logic [15:0] C_AI  = 16'h1 << B_AI;
   localparam logic [15:0] C_AO  = 16'h1 << B_AO;
   localparam logic [15:0] C_EO  = 16'h1 << B_EO;
   localparam logic [15:0] C_SU  = 16'h1 << B_SU;
   localparam logic [15:0] C_BI  = 16'h1 << B_BI;
   localparam logic [15:0] C_OI  = 16'h1 << B_OI;
   localparam logic [15:0] C_CE  = 16'h1 << B_CE;
   localparam logic [15:0] C_CO  = 16'h1 << B_CO;
   localparam logic [15:0] C_J   = 16'h1 << B_J;
   localparam logic [15:0] C_FI  = 16'h1 << B_FI;

   // Opcodes 1001..1101 have no execute phase and retire after fetch.
   function automatic logic is_undef(input logic [3:0] op);
      return (op >= 4'b1001) && (op <= 4'b1101);
   endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode table: opcode/step/flags -> control word, last.
// Ports: opcode[3:0], step[2:0], cf, zf in; ctrl[15:0], last out.
module microcode_rom
   import kwan_cpu_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic [2:0]  step,
   input  logic        cf,
   input  logic        zf,
   output logic [15:0] ctrl,
   output logic        last
);

   always_comb begin
      ctrl = '0;
      last = 1'b0;
      case (step)
         3'd0: ctrl = C_MI | C_CO;
         3'd1: begin
            ctrl = C_RO | C_II | C_CE;
            last = (opcode == OP_NOP) || is_undef(opcode);
         end
         3'd2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = C_IO | C_MI;
               OP_LDI: begin
                  ctrl = C_IO | C_AI;
                  last = 1'b1;
               end
               OP_JMP: begin
                  ctrl = C_IO | C_J;
                  last = 1'b1;
               end
               // Conditional jumps retire here whether taken or not.
               OP_JC: begin
                  ctrl = cf ? (C_IO | C_J) : 16'h0;
                  last = 1'b1;
               end
               OP_JZ: begin
                  ctrl = zf ? (C_IO | C_J) : 16'h0;
                  last = 1'b1;
               end
               OP_OUT: begin
                  ctrl = C_AO | C_OI;
                  last = 1'b1;
               end
               OP_HLT: begin
                  ctrl = C_HLT;
                  last = 1'b1;
               end
               default: ctrl = '0;
            endcase
         end
         3'd3: begin
            case (opcode)
               OP_LDA: begin
                  ctrl = C_RO | C_AI;
                  last = 1'b1;
               end
               OP_ADD, OP_SUB: ctrl = C_RO | C_BI;
               OP_STA: begin
                  ctrl = C_AO | C_RI;
                  last = 1'b1;
               end
               default: ctrl = '0;
            endcase
         end
         3'd4: begin
            case (opcode)
               OP_ADD: begin
                  ctrl = C_AI | C_EO | C_FI;
                  last = 1'b1;
               end
               OP_SUB: begin
                  ctrl = C_AI | C_EO | C_SU | C_FI;
                  last = 1'b1;
               end
               default: ctrl = '0;
            endcase
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: step counter, halt latch, prog/halt output muxing.
// Ports: clk, clr, prog, irval[N-1:0], cf, zf in; ctrl, step, instr_done, halted out.
module control_sequencer
   import kwan_cpu_pkg::*;
#(
   parameter int N     = 8,
   parameter int STEPS = kwan_cpu_pkg::STEPS
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         prog,
   input  logic [N-1:0] irval,
   input  logic         cf,
   input  logic         zf,
   output logic [15:0]  ctrl,
   output logic [2:0]   step,
   output logic         instr_done,
   output logic         halted
);

   logic [3:0]  opcode;
   logic [15:0] rom_ctrl;
   logic        rom_last;
   logic        hlt_now;
   logic        unused_bits;

   assign opcode      = irval[N-1 -: 4];
   assign unused_bits = ^irval[N-5:0];

   microcode_rom u_rom (
      .opcode (opcode),
      .step   (step),
      .cf     (cf),
      .zf     (zf),
      .ctrl   (rom_ctrl),
      .last   (rom_last)
   );

   always_comb begin
      ctrl       = '0;
      instr_done = 1'b0;
      if (!prog) begin
         ctrl       = '0;
         instr_done = 1'b0;
      end else if (halted) begin
         ctrl       = C_HLT;
         instr_done = 1'b0;
      end else begin
         ctrl       = rom_ctrl;
         instr_done = rom_last;
      end
   end

   // HLT step: latch halt and park the counter at T2 instead of wrapping.
   assign hlt_now = prog && !halted && rom_ctrl[B_HLT];

   always_ff @(posedge clk) begin
      if (clr) begin
         step   <= 3'd0;
         halted <= 1'b0;
      end else if (!prog) begin
         step   <= 3'd0;
         halted <= 1'b0;
      end else if (halted) begin
         step <= step;
      end else if (hlt_now) begin
         halted <= 1'b1;
      end else if (instr_done || step >= 3'(STEPS - 1)) begin
         step <= 3'd0;
      end else begin
         step <= step + 3'd1;
      end
   end

endmodule
